// File: rtl/hbmc_dfifo_sc_if.sv
// Bus-side bundle of the single-clock downstream data FIFO.
// The master modport is the producer/consumer pair around the FIFO;
// the slave modport is the FIFO itself.
interface hbmc_dfifo_sc_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Write side (32-bit words from the bus write-data path)
  logic [31:0]      fifo_wr_din;
  logic [3:0]       fifo_wr_strb;
  logic             fifo_wr_last;
  logic             fifo_wr_ena;
  logic             fifo_wr_full;
  logic [CNT_W-1:0] fifo_wr_free;

  // Read side (16-bit halfwords towards the HyperBus transmit datapath)
  logic [15:0]      fifo_rd_dout;
  logic [1:0]       fifo_rd_mask;
  logic             fifo_rd_last;
  logic             fifo_rd_ena;
  logic             fifo_rd_empty;

  modport master (
    output fifo_wr_din, fifo_wr_strb, fifo_wr_last, fifo_wr_ena, fifo_rd_ena,
    input  fifo_wr_full, fifo_wr_free, fifo_rd_dout, fifo_rd_mask,
           fifo_rd_last, fifo_rd_empty
  );

  modport slave (
    input  fifo_wr_din, fifo_wr_strb, fifo_wr_last, fifo_wr_ena, fifo_rd_ena,
    output fifo_wr_full, fifo_wr_free, fifo_rd_dout, fifo_rd_mask,
           fifo_rd_last, fifo_rd_empty
  );
endinterface

// File: rtl/hbmc_dfifo_sc.sv
// Single-clock downstream data FIFO for the HyperBus controller.
// Stores {last, strb, din} 32-bit entries and hands them out as two
// 16-bit halfwords (low first) with an RWDS mask, first-word-fall-through.
module hbmc_dfifo_sc #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           fifo_clk,
  input  logic           fifo_arst,
  hbmc_dfifo_sc_if.slave fifo
);

  localparam int HALF_W = DATA_WIDTH / 2;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = AW + 1;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic              last;
    logic [STRB_W-1:0] strb;
    logic [DATA_WIDTH-1:0] din;
  } entry_t;

  entry_t           mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             half;

  logic   full;
  logic   empty;
  logic   push_ok;
  logic   pop_ok;
  logic   release_entry;
  entry_t head;

  // Status is a pure function of the entry count; a half-consumed entry
  // still occupies its slot until its high halfword is popped.
  assign full  = (cnt == DEPTH_CNT);
  assign empty = (cnt == '0);

  // Both acceptance terms look at pre-edge state only: a full FIFO refuses a
  // push even if the same edge frees a slot, and an empty FIFO ignores a pop
  // even if the same edge stores a word.
  assign push_ok       = fifo.fifo_wr_ena && !full;
  assign pop_ok        = fifo.fifo_rd_ena && !empty;
  assign release_entry = pop_ok && half;

  // Storage array write; contents are deliberately left out of reset.
  // NOTE: the data array has no reset - pointers and count define validity,
  // so clearing storage would only add reset fan-out for no functional gain.
  always_ff @(posedge fifo_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= '{last: fifo.fifo_wr_last,
                       strb: fifo.fifo_wr_strb,
                       din:  fifo.fifo_wr_din};
    end
  end

  // Pointer, halfword-select and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge fifo_clk or posedge fifo_arst) begin
    if (fifo_arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      half   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        half <= ~half;
        if (half) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
      unique case ({push_ok, release_entry})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // Read-side presentation: select the current halfword of the head entry,
  // invert its strobes into the RWDS mask, and force zeros while empty.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    fifo.fifo_rd_dout = '0;
    fifo.fifo_rd_mask = '0;
    fifo.fifo_rd_last = 1'b0;
    if (!empty) begin
      if (half) begin
        fifo.fifo_rd_dout = head.din[DATA_WIDTH-1:HALF_W];
        fifo.fifo_rd_mask = ~head.strb[STRB_W-1:STRB_W/2];
        fifo.fifo_rd_last = head.last;
      end else begin
        fifo.fifo_rd_dout = head.din[HALF_W-1:0];
        fifo.fifo_rd_mask = ~head.strb[STRB_W/2-1:0];
      end
    end
  end

  assign fifo.fifo_wr_full  = full;
  assign fifo.fifo_wr_free  = DEPTH_CNT - cnt;
  assign fifo.fifo_rd_empty = empty;

endmodule

// File: tb/tb_hbmc_dfifo_sc.sv
// Self-checking bench for hbmc_dfifo_sc: directed scenarios plus random
// traffic, checked by a halfword scoreboard fed from a queue-based model.
module tb_hbmc_dfifo_sc;

  localparam int DEPTH = 16;

  typedef struct {
    logic [15:0] dout;
    logic [1:0]  mask;
    logic        last;
  } half_t;

  logic fifo_clk  = 1'b0;
  logic fifo_arst = 1'b1;

  hbmc_dfifo_sc_if #(.FIFO_DEPTH(DEPTH)) bus ();

  hbmc_dfifo_sc #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
    .fifo_clk  (fifo_clk),
    .fifo_arst (fifo_arst),
    .fifo      (bus)
  );

  always #5 fifo_clk = ~fifo_clk;

  // Reference model: the halfwords still owed by the FIFO, in order.
  half_t       exp_q[$];
  logic        pend_push = 1'b0;
  logic [31:0] pend_din;
  logic [3:0]  pend_strb;
  logic        pend_last;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_entries();
    return (exp_q.size() + 1) / 2;
  endfunction

  // One cycle of stimulus: commit the push accepted at the previous edge into
  // the model, then drive new inputs and decide whether the coming push fits.
  task automatic step(input logic wr, input logic rd, input logic [31:0] din,
                      input logic [3:0] strb, input logic last);
    @(posedge fifo_clk);
    #1;
    if (pend_push) begin
      exp_q.push_back('{dout: pend_din[15:0],  mask: ~pend_strb[1:0], last: 1'b0});
      exp_q.push_back('{dout: pend_din[31:16], mask: ~pend_strb[3:2], last: pend_last});
    end
    bus.fifo_wr_ena  = wr;
    bus.fifo_rd_ena  = rd;
    bus.fifo_wr_din  = din;
    bus.fifo_wr_strb = strb;
    bus.fifo_wr_last = last;
    pend_push = wr && (model_entries() < DEPTH);
    pend_din  = din;
    pend_strb = strb;
    pend_last = last;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"}, 32'(bus.fifo_rd_empty), 32'd1);
    check({tag, "_full"},  32'(bus.fifo_wr_full),  32'd0);
    check({tag, "_free"},  32'(bus.fifo_wr_free),  32'd16);
    check({tag, "_dout"},  32'(bus.fifo_rd_dout),  32'd0);
    check({tag, "_mask"},  32'(bus.fifo_rd_mask),  32'd0);
    check({tag, "_last"},  32'(bus.fifo_rd_last),  32'd0);
  endtask

  // Monitor: on every falling edge compare status against the model and, when
  // data is owed, the presented halfword; retire it if a pop is being issued.
  always @(negedge fifo_clk) begin
    int ent;
    ent = model_entries();
    check("mon_empty", 32'(bus.fifo_rd_empty), 32'(ent == 0));
    check("mon_full",  32'(bus.fifo_wr_full),  32'(ent == DEPTH));
    check("mon_free",  32'(bus.fifo_wr_free),  32'(DEPTH - ent));
    if (exp_q.size() == 0) begin
      check("mon_idle_data", {13'd0, bus.fifo_rd_last, bus.fifo_rd_mask, bus.fifo_rd_dout}, 32'd0);
    end else begin
      check("mon_dout", 32'(bus.fifo_rd_dout), 32'(exp_q[0].dout));
      check("mon_mask", 32'(bus.fifo_rd_mask), 32'(exp_q[0].mask));
      check("mon_last", 32'(bus.fifo_rd_last), 32'(exp_q[0].last));
      if (bus.fifo_rd_ena && !fifo_arst) begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bus.fifo_wr_ena  = 1'b0;
    bus.fifo_rd_ena  = 1'b0;
    bus.fifo_wr_din  = '0;
    bus.fifo_wr_strb = '0;
    bus.fifo_wr_last = 1'b0;

    #3;
    check_reset_outputs("rst");
    #9;
    fifo_arst = 1'b0;
    idle();
    idle();
    check_reset_outputs("idle");

    // Single word, two halfwords.
    step(1'b1, 1'b0, 32'hA1B2C3D4, 4'hF, 1'b1);
    step(1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
    check("w1_lo_dout", 32'(bus.fifo_rd_dout), 32'hC3D4);
    check("w1_lo_mask", 32'(bus.fifo_rd_mask), 32'h0);
    check("w1_lo_last", 32'(bus.fifo_rd_last), 32'h0);
    step(1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
    check("w1_hi_dout", 32'(bus.fifo_rd_dout), 32'hA1B2);
    check("w1_hi_mask", 32'(bus.fifo_rd_mask), 32'h0);
    check("w1_hi_last", 32'(bus.fifo_rd_last), 32'h1);
    idle();
    check("w1_empty", 32'(bus.fifo_rd_empty), 32'd1);
    check("w1_free",  32'(bus.fifo_wr_free),  32'd16);

    // Strobe to mask mapping.
    step(1'b1, 1'b0, 32'h11223344, 4'b0110, 1'b0);
    step(1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
    check("strb_lo_mask", 32'(bus.fifo_rd_mask), 32'b01);
    step(1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
    check("strb_hi_mask", 32'(bus.fifo_wr_free) == 32'd15 ? 32'(bus.fifo_rd_mask) : 32'hFF, 32'b10);
    idle();

    // Fill to full (pointers wrap since two entries were already consumed).
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 32'h5A000000 | 32'(i * 32'h00010101), 4'hF, i == DEPTH - 1);
    end
    step(1'b1, 1'b0, 32'hDEADBEEF, 4'hF, 1'b1);
    check("fill_full", 32'(bus.fifo_wr_full), 32'd1);
    check("fill_free", 32'(bus.fifo_wr_free), 32'd0);
    idle();
    check("drop_full", 32'(bus.fifo_wr_full), 32'd1);

    // Full boundary: pop low half, then push+pop on the high half.
    step(1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 32'hCAFEF00D, 4'hF, 1'b0);
    check("bnd_still_full", 32'(bus.fifo_wr_full), 32'd1);
    idle();
    check("bnd_free_one", 32'(bus.fifo_wr_free), 32'd1);
    for (int i = 0; i < 2 * DEPTH - 2; i++) begin
      step(1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
    end
    idle();
    check("drain_empty", 32'(bus.fifo_rd_empty), 32'd1);

    // Empty boundary: push+pop while empty keeps the low half pending.
    step(1'b1, 1'b1, 32'h76543210, 4'hF, 1'b0);
    idle();
    check("emp_not_empty", 32'(bus.fifo_rd_empty), 32'd0);
    check("emp_lo_dout",   32'(bus.fifo_rd_dout),  32'h3210);
    step(1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
    idle();

    // Reset mid-burst after 5 pushes and 3 pops.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'h10203040 + 32'(i), 4'hF, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
    end
    @(posedge fifo_clk);
    #2;
    fifo_arst       = 1'b1;
    bus.fifo_wr_ena = 1'b0;
    bus.fifo_rd_ena = 1'b0;
    exp_q.delete();
    pend_push = 1'b0;
    #1;
    check_reset_outputs("arst");
    @(negedge fifo_clk);
    #1;
    fifo_arst = 1'b0;
    step(1'b1, 1'b0, 32'h9ABC1357, 4'h3, 1'b1);
    idle();
    check("post_rst_dout", 32'(bus.fifo_rd_dout), 32'h1357);
    check("post_rst_mask", 32'(bus.fifo_rd_mask), 32'b00);
    check("post_rst_last", 32'(bus.fifo_rd_last), 32'd0);

    // Random traffic with phases biased towards filling and draining.
    for (int i = 0; i < 3000; i++) begin
      int wr_pct;
      int rd_pct;
      wr_pct = ((i / 200) % 2 == 0) ? 80 : 30;
      rd_pct = ((i / 200) % 2 == 0) ? 40 : 85;
      step($urandom_range(99) < wr_pct, $urandom_range(99) < rd_pct,
           $urandom, 4'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 2 * DEPTH + 2; i++) begin
      step(1'b0, 1'b1, 32'h0, 4'h0, 1'b0);
    end
    idle();
    check("final_empty", 32'(bus.fifo_rd_empty), 32'd1);
    check("final_model_empty", 32'(exp_q.size()), 32'd0);

    @(posedge fifo_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
